// File: rtl/divider_seq_u16_if.sv
// ----------------------------------------------------------------------------
// divider_seq_u16_if
// Request/result bundle for the sequential unsigned divider.
//   dividend  : numerator, driven by the master, sampled on the accept edge
//   divider   : denominator, driven by the master, sampled on the accept edge
//   start     : request level; a low-to-high transition launches a divide
//   quotient  : registered quotient, valid while ready=1 after a divide
//   remainder : registered remainder, valid while ready=1 after a divide
//   ready     : 1 = idle with results valid, 0 = busy or request pending
// Modports: master (requester side), slave (divider side).
// ----------------------------------------------------------------------------
interface divider_seq_u16_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divider;
    logic             start;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;

    modport master (
        output dividend,
        output divider,
        output start,
        input  quotient,
        input  remainder,
        input  ready
    );

    modport slave (
        input  dividend,
        input  divider,
        input  start,
        output quotient,
        output remainder,
        output ready
    );
endinterface

// File: rtl/divider_seq_u16.sv
// ----------------------------------------------------------------------------
// divider_seq_u16
// Multi-cycle unsigned divider, restoring shift-subtract, one quotient bit per
// clock. A divide takes WIDTH clocks from the accept edge to ready=1.
// Divide by zero yields quotient = all ones, remainder = dividend.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (aborts any divide in progress)
//   bus  : divider_seq_u16_if.slave (dividend/divider/start in,
//          quotient/remainder/ready out)
// ----------------------------------------------------------------------------
module divider_seq_u16 #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    divider_seq_u16_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_start_d;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    // Working registers; only meaningful while busy, so they carry no reset.
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;

    logic             w_req;
    logic             w_busy;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Request is a rising level of start; a level held high never re-triggers.
    assign w_req    = bus.start & ~r_start_d;
    assign w_busy   = (r_state == S_BUSY);
    assign w_accept = w_req & ~w_busy;
    assign w_last   = w_busy && (r_cnt == CNT_W'(1));

    // ready drops combinationally as soon as a new request shows up.
    assign bus.ready     = ~w_busy & ~w_req;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The trial value needs WIDTH+1 bits for the compare; when the subtract is
    // taken the result is below the divider, so WIDTH-bit arithmetic suffices.
    // With divider=0 every step subtracts nothing and sets the quotient bit,
    // which gives all-ones / dividend without a special case.
    assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dvs});
    assign w_diff    = w_trial[WIDTH-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY: if (w_last)   w_state_nxt = S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= bus.start;
            if (w_accept) begin
                r_cnt <= CNT_W'(WIDTH);
            end else if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Results are published on the edge the last step completes.
            if (w_last) begin
                r_quotient  <= w_quo_nxt;
                r_remainder <= w_rem_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dvd <= bus.dividend;
            r_dvs <= bus.divider;
            r_rem <= '0;
            r_quo <= '0;
        end else if (w_busy) begin
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end
endmodule

// File: tb/tb_divider_seq_u16.sv
// ----------------------------------------------------------------------------
// tb_divider_seq_u16
// Directed and randomized checks of divider_seq_u16 against plain arithmetic.
// ----------------------------------------------------------------------------
module tb_divider_seq_u16;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divider_seq_u16_if #(.WIDTH(16)) u_if ();

    divider_seq_u16 #(.WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'hFFFF : a / b;
    endfunction

    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? a : a % b;
    endfunction

    // One idle cycle with start low, then raise start with the operands.
    // Operands are scrambled after the accept edge; a start re-rise while
    // busy is optionally injected. Leaves start high on return.
    task automatic launch_and_wait(input string tag, input logic [15:0] a,
                                   input logic [15:0] b, input bit poke_busy);
        int cycles;
        tick();
        u_if.dividend = a;
        u_if.divider  = b;
        u_if.start    = 1'b1;
        tick();
        check({tag, "_ready_low"}, u_if.ready, 1'b0);
        u_if.dividend = 16'($urandom);
        u_if.divider  = 16'($urandom);
        cycles = 0;
        while (!u_if.ready && cycles < 100) begin
            if (poke_busy && cycles == 3) u_if.start = 1'b0;
            if (poke_busy && cycles == 5) u_if.start = 1'b1;
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, 16);
        check({tag, "_q"}, u_if.quotient, ref_q(a, b));
        check({tag, "_r"}, u_if.remainder, ref_r(a, b));
    endtask

    task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b);
        launch_and_wait(tag, a, b, 1'b0);
        u_if.start = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hq;
        logic [15:0] hr;
        int          cyc;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        u_if.start    = 1'b0;
        u_if.dividend = '0;
        u_if.divider  = '0;
        #2;
        check("rst_q", u_if.quotient, 16'd0);
        check("rst_r", u_if.remainder, 16'd0);
        check("rst_ready", u_if.ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_ready", u_if.ready, 1'b1);

        do_div("d100_7", 16'd100, 16'd7);
        do_div("d3_10", 16'd3, 16'd10);
        do_div("d0_5", 16'd0, 16'd5);
        do_div("d65535_1", 16'd65535, 16'd1);
        do_div("d5_0", 16'd5, 16'd0);

        // Start held high after completion must not relaunch.
        launch_and_wait("hold", 16'd4321, 16'd17, 1'b0);
        hq = ref_q(16'd4321, 16'd17);
        hr = ref_r(16'd4321, 16'd17);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("hold_ready", u_if.ready, 1'b1);
            check("hold_q", u_if.quotient, hq);
            check("hold_r", u_if.remainder, hr);
        end
        u_if.start = 1'b0;

        // Start re-rise while busy is ignored.
        launch_and_wait("busy_poke", 16'd50000, 16'd123, 1'b1);
        u_if.start = 1'b0;

        // Asynchronous reset in the middle of a divide.
        tick();
        u_if.dividend = 16'd40000;
        u_if.divider  = 16'd3;
        u_if.start    = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy", u_if.ready, 1'b0);
        #1;
        u_if.start = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", u_if.ready, 1'b1);
        check("mid_rst_q", u_if.quotient, 16'd0);
        check("mid_rst_r", u_if.remainder, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
        end
        check("post_rst_q", u_if.quotient, 16'd0);
        check("post_rst_ready", u_if.ready, 1'b1);
        do_div("d1000_33", 16'd1000, 16'd33);

        // Back-to-back: start dropped on the ready cycle, re-raised next clock.
        do_div("d2000_9", 16'd2000, 16'd9);

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 3));
                1:       b = 16'($urandom_range(1, 255));
                2:       b = a;
                default: b = 16'($urandom);
            endcase
            launch_and_wait("rand", a, b, bit'($urandom_range(0, 1)));
            u_if.start = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
